flex_updown_counter: RTL and testbench
======================================

Name: flex_updown_counter

Overview:
- Parametrised successor to the team's flex counter. Adds up/down direction, synchronous parallel load and a single-cycle wrap pulse.
- Adds an optional saturating wrap-event counter.
- Used as a general-purpose timer, bit counter or credit counter inside protocol receivers and FSM datapaths. Replaces ad-hoc counters in those blocks.

Parameters:
NUM_CNT_BITS, 4, width of count_out, load_val and rollover_val (legal 1..16)
WRAP_CNT_BITS, 4, width of wrap_count (only meaningful with FLEX_CNT_WRAP_CNT_EN)

Ports:
clk  input  1  system clock, all state updates on rising edge
n_rst  input  1  asynchronous active-low reset
clear  input  1  synchronous clear, highest synchronous priority
load  input  1  synchronous load of load_val
load_val  input  NUM_CNT_BITS  value loaded when load=1
count_enable  input  1  advance count one step this cycle
count_dir  input  1  1 = count up, 0 = count down
rollover_val  input  NUM_CNT_BITS  terminal (top) value of count range 1..rollover_val
count_out  output  NUM_CNT_BITS  registered count value
rollover_flag  output  1  registered; high while count_out == rollover_val
wrap_pulse  output  1  registered; one-cycle pulse the cycle after a wrap occurred
wrap_count  output  WRAP_CNT_BITS  saturating number of wraps since reset/clear (feature-gated)

Behaviour:
- Reset (n_rst=0, asynchronous, any time): count_out=0, rollover_flag=0, wrap_pulse=0, wrap_count=0. Outputs are held for as long as n_rst=0.
- All outputs are registered. Every output reflects the inputs sampled at the previous rising edge, giving 1-cycle latency.
- Synchronous priority per cycle: clear > load > count_enable > hold.
- clear=1:
  - next count = 0.
  - wrap_pulse = 0.
  - wrap_count = 0.
- load=1 (clear=0):
  - next count = load_val. Any value is accepted, including values > rollover_val.
  - No wrap pulse. wrap_count unchanged.
- count_enable=1, count_dir=1 (up):
  - If count_out >= rollover_val, next = 1 and this is a wrap event. This includes a mid-run lowering of rollover_val below count_out.
  - Otherwise next = count_out + 1.
- count_enable=1, count_dir=0 (down):
  - If count_out <= 1, next = rollover_val and this is a wrap event. This includes count_out = 0 after reset or clear.
  - Else if count_out > rollover_val, next = rollover_val (clamp, not a wrap).
  - Otherwise next = count_out - 1.
- rollover_val == 0 (degenerate):
  - count_enable forces next = 0 in either direction.
  - No wrap event.
  - rollover_flag = 1 while count_out == 0.
- Hold: count_out is unchanged when count_enable=0, clear=0 and load=0.
- rollover_flag:
  - Evaluated every cycle as flag_next = (next count == rollover_val), sampled at the same edge.
  - If rollover_val changes while holding, the flag tracks it one cycle later.
- wrap_pulse:
  - Equals 1 for exactly the cycle following an edge at which a wrap event was taken.
  - Back-to-back wraps produce back-to-back pulses. Example: rollover_val=1, counting up gives a pulse every cycle.
- Arithmetic is unsigned, NUM_CNT_BITS wide. No overflow is possible, because the wrap rule applies before any +1 can exceed the range.
- A reset asserted mid-count overrides everything immediately. After release, the counter resumes from 0 on the next enabled edge.

Optional Feature:
- Macro: FLEX_CNT_WRAP_CNT_EN.
- Defined:
  - wrap_count increments by 1 on every wrap event.
  - Saturates at 2^WRAP_CNT_BITS-1.
  - Cleared by n_rst and by clear. Unaffected by load.
- Not defined:
  - wrap_count is tied to 0.
  - No wrap-count registers are synthesised. The port remains for a uniform interface.

Test Plan:
- Reset and hold check:
  - Stimulus: n_rst=0 mid-count with count_out=5.
  - Required: count_out=0, rollover_flag=0 and wrap_pulse=0 immediately, held through a clock edge while in reset; still 0 after release.
- Up count with wrap:
  - Stimulus: rollover_val=3, count_dir=1, enable for 7 cycles.
  - Required: count_out sequence 1,2,3,1,2,3,1.
  - rollover_flag=1 only at the 3s.
  - wrap_pulse on the cycles showing 1 after a 3 (the 4th and 7th values).
- Down count with wrap:
  - Stimulus: rollover_val=4, count_dir=0, starting from reset, enable for 6 cycles.
  - Required: count_out sequence 4,3,2,1,4,3.
  - wrap_pulse with the 1st and 5th values.
  - rollover_flag with the 4s.
- Priority:
  - Stimulus: clear=1, load=1 (load_val=9) and count_enable=1 in the same cycle.
  - Required: count_out=0.
  - Next cycle, with load=1 only: count_out=9, rollover_flag=0 (rollover_val=10), no wrap_pulse.
- Mid-run rollover_val change:
  - Stimulus: count_out=7, set rollover_val=5.
  - Required: counting up gives next=1 with wrap_pulse. Counting down instead gives next=5, no pulse, rollover_flag=1.
- Wrap counter (macro defined, WRAP_CNT_BITS=2):
  - Stimulus: rollover_val=1, counting up for 6 cycles.
  - Required: wrap_count sequence 1,2,3,3,3,3 (saturates).
  - clear returns it to 0. Without the macro, wrap_count=0 throughout.

Source files
------------

// File: rtl/flex_updown_counter_if.sv
// Control/status bundle for flex_updown_counter.
// The master drives the controls and the slave (the counter) drives the status.
interface flex_updown_counter_if #(
    parameter int NUM_CNT_BITS  = 4,
    parameter int WRAP_CNT_BITS = 4
);
    logic                     clear;
    logic                     load;
    logic [NUM_CNT_BITS-1:0]  load_val;
    logic                     count_enable;
    logic                     count_dir;
    logic [NUM_CNT_BITS-1:0]  rollover_val;
    logic [NUM_CNT_BITS-1:0]  count_out;
    logic                     rollover_flag;
    logic                     wrap_pulse;
    logic [WRAP_CNT_BITS-1:0] wrap_count;

    modport master (
        output clear, load, load_val, count_enable, count_dir, rollover_val,
        input  count_out, rollover_flag, wrap_pulse, wrap_count
    );

    modport slave (
        input  clear, load, load_val, count_enable, count_dir, rollover_val,
        output count_out, rollover_flag, wrap_pulse, wrap_count
    );
endinterface

// File: rtl/flex_updown_counter.sv
// Up/down counter over 1..rollover_val with sync clear/load, registered flag and wrap pulse.
// Define FLEX_CNT_WRAP_CNT_EN to build the saturating wrap-event counter on wrap_count.
module flex_updown_counter #(
    parameter int NUM_CNT_BITS  = 4,
    parameter int WRAP_CNT_BITS = 4
) (
    input logic                clk,
    input logic                n_rst,
    flex_updown_counter_if.slave bus
);
    typedef logic [NUM_CNT_BITS-1:0] cnt_t;

    cnt_t cnt_next;
    logic wrap_evt;
    logic flag_next;

    always_comb begin
        cnt_next = bus.count_out;
        wrap_evt = 1'b0;
        if (bus.clear) begin
            cnt_next = '0;
        end else if (bus.load) begin
            cnt_next = bus.load_val;
        end else if (bus.count_enable) begin
            if (bus.rollover_val == '0) begin
                cnt_next = '0;
            end else if (bus.count_dir) begin
                // Covers rollover_val being lowered below the current count.
                if (bus.count_out >= bus.rollover_val) begin
                    cnt_next = cnt_t'(1);
                    wrap_evt = 1'b1;
                end else begin
                    cnt_next = bus.count_out + cnt_t'(1);
                end
            end else begin
                // 0 (after reset/clear) wraps to the top just like 1 does.
                if (bus.count_out <= cnt_t'(1)) begin
                    cnt_next = bus.rollover_val;
                    wrap_evt = 1'b1;
                end else if (bus.count_out > bus.rollover_val) begin
                    cnt_next = bus.rollover_val;
                end else begin
                    cnt_next = bus.count_out - cnt_t'(1);
                end
            end
        end
        flag_next = (cnt_next == bus.rollover_val);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus.count_out     <= '0;
            bus.rollover_flag <= 1'b0;
            bus.wrap_pulse    <= 1'b0;
        end else begin
            bus.count_out     <= cnt_next;
            bus.rollover_flag <= flag_next;
            bus.wrap_pulse    <= wrap_evt;
        end
    end

`ifdef FLEX_CNT_WRAP_CNT_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus.wrap_count <= '0;
        end else if (bus.clear) begin
            bus.wrap_count <= '0;
        end else if (wrap_evt && !(&bus.wrap_count)) begin
            bus.wrap_count <= bus.wrap_count + WRAP_CNT_BITS'(1);
        end
    end
`else
    assign bus.wrap_count = '0;
`endif

endmodule

// File: tb/tb_flex_updown_counter.sv
// Directed self-checking bench for flex_updown_counter (NUM_CNT_BITS=4, WRAP_CNT_BITS=2).
module tb_flex_updown_counter;
    localparam int NB = 4;
    localparam int WB = 2;

    logic tb_clk = 1'b0;
    logic n_rst;
    int   n_checks = 0;
    int   n_errors = 0;

    flex_updown_counter_if #(.NUM_CNT_BITS(NB), .WRAP_CNT_BITS(WB)) bus ();

    flex_updown_counter #(.NUM_CNT_BITS(NB), .WRAP_CNT_BITS(WB)) dut (
        .clk   (tb_clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    always #5 tb_clk = ~tb_clk;

    // Inputs are changed 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic idle();
        bus.clear = 0; bus.load = 0; bus.count_enable = 0;
    endtask

    task automatic do_clear();
        idle(); bus.clear = 1; step(); bus.clear = 0;
    endtask

    task automatic do_load(input logic [NB-1:0] v);
        idle(); bus.load = 1; bus.load_val = v; step(); bus.load = 0;
    endtask

    task automatic test_reset();
        bus.rollover_val = 5;
        do_load(5);
        n_checks++;
        if (bus.count_out !== 4'd5 || bus.rollover_flag !== 1'b1) begin
            n_errors++; $display("FAIL preload: count=%0d flag=%b want 5/1", bus.count_out, bus.rollover_flag);
        end
        bus.count_enable = 1; bus.count_dir = 1;
        n_rst = 0; #1;
        n_checks++;
        if (bus.count_out !== 0 || bus.rollover_flag !== 0 || bus.wrap_pulse !== 0 || bus.wrap_count !== 0) begin
            n_errors++; $display("FAIL reset_async: count=%0d flag=%b pulse=%b wc=%0d want 0", bus.count_out, bus.rollover_flag, bus.wrap_pulse, bus.wrap_count);
        end
        step();
        n_checks++;
        if (bus.count_out !== 0 || bus.rollover_flag !== 0 || bus.wrap_pulse !== 0) begin
            n_errors++; $display("FAIL reset_hold: count=%0d flag=%b pulse=%b want 0", bus.count_out, bus.rollover_flag, bus.wrap_pulse);
        end
        idle();
        n_rst = 1; #1;
        n_checks++;
        if (bus.count_out !== 0 || bus.rollover_flag !== 0 || bus.wrap_pulse !== 0) begin
            n_errors++; $display("FAIL reset_release: count=%0d flag=%b pulse=%b want 0", bus.count_out, bus.rollover_flag, bus.wrap_pulse);
        end
    endtask

    task automatic test_up_wrap();
        int   ec [7] = '{1, 2, 3, 1, 2, 3, 1};
        logic ef [7] = '{0, 0, 1, 0, 0, 1, 0};
        logic ep [7] = '{0, 0, 0, 1, 0, 0, 1};
        do_clear();
        bus.rollover_val = 3; bus.count_dir = 1; bus.count_enable = 1;
        for (int i = 0; i < 7; i++) begin
            step();
            n_checks++;
            if (bus.count_out !== NB'(ec[i]) || bus.rollover_flag !== ef[i] || bus.wrap_pulse !== ep[i]) begin
                n_errors++;
                $display("FAIL up_wrap[%0d]: count=%0d flag=%b pulse=%b want %0d/%b/%b",
                         i, bus.count_out, bus.rollover_flag, bus.wrap_pulse, ec[i], ef[i], ep[i]);
            end
        end
        idle();
    endtask

    task automatic test_down_wrap();
        int   ec [6] = '{4, 3, 2, 1, 4, 3};
        logic ef [6] = '{1, 0, 0, 0, 1, 0};
        logic ep [6] = '{1, 0, 0, 0, 1, 0};
        idle();
        n_rst = 0; #1; n_rst = 1;
        bus.rollover_val = 4; bus.count_dir = 0; bus.count_enable = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (bus.count_out !== NB'(ec[i]) || bus.rollover_flag !== ef[i] || bus.wrap_pulse !== ep[i]) begin
                n_errors++;
                $display("FAIL down_wrap[%0d]: count=%0d flag=%b pulse=%b want %0d/%b/%b",
                         i, bus.count_out, bus.rollover_flag, bus.wrap_pulse, ec[i], ef[i], ep[i]);
            end
        end
        idle();
    endtask

    task automatic test_priority();
        bus.rollover_val = 10; do_load(4);
        bus.clear = 1; bus.load = 1; bus.load_val = 9; bus.count_enable = 1; bus.count_dir = 1;
        step();
        n_checks++;
        if (bus.count_out !== 0 || bus.wrap_pulse !== 0) begin
            n_errors++; $display("FAIL prio_clear: count=%0d pulse=%b want 0/0", bus.count_out, bus.wrap_pulse);
        end
        idle(); bus.load = 1;
        step();
        n_checks++;
        if (bus.count_out !== 4'd9 || bus.rollover_flag !== 0 || bus.wrap_pulse !== 0) begin
            n_errors++; $display("FAIL prio_load: count=%0d flag=%b pulse=%b want 9/0/0", bus.count_out, bus.rollover_flag, bus.wrap_pulse);
        end
        // Load beats count_enable.
        bus.load_val = 2; bus.count_enable = 1;
        step();
        n_checks++;
        if (bus.count_out !== 4'd2) begin
            n_errors++; $display("FAIL prio_load_en: count=%0d want 2", bus.count_out);
        end
        idle();
        step();
        n_checks++;
        if (bus.count_out !== 4'd2 || bus.rollover_flag !== 0) begin
            n_errors++; $display("FAIL hold: count=%0d flag=%b want 2/0", bus.count_out, bus.rollover_flag);
        end
        // Flag follows a rollover_val change while holding, one cycle later.
        bus.rollover_val = 2;
        step();
        n_checks++;
        if (bus.count_out !== 4'd2 || bus.rollover_flag !== 1) begin
            n_errors++; $display("FAIL hold_flag: count=%0d flag=%b want 2/1", bus.count_out, bus.rollover_flag);
        end
    endtask

    task automatic test_midrun_change();
        bus.rollover_val = 10; do_load(7);
        bus.rollover_val = 5; bus.count_dir = 1; bus.count_enable = 1;
        step();
        n_checks++;
        if (bus.count_out !== 4'd1 || bus.wrap_pulse !== 1 || bus.rollover_flag !== 0) begin
            n_errors++; $display("FAIL midrun_up: count=%0d pulse=%b flag=%b want 1/1/0", bus.count_out, bus.wrap_pulse, bus.rollover_flag);
        end
        do_load(7);
        bus.count_dir = 0; bus.count_enable = 1;
        step();
        n_checks++;
        if (bus.count_out !== 4'd5 || bus.wrap_pulse !== 0 || bus.rollover_flag !== 1) begin
            n_errors++; $display("FAIL midrun_down: count=%0d pulse=%b flag=%b want 5/0/1", bus.count_out, bus.wrap_pulse, bus.rollover_flag);
        end
        idle();
    endtask

    task automatic test_degenerate();
        bus.rollover_val = 0; do_load(6);
        bus.count_dir = 1; bus.count_enable = 1;
        step();
        n_checks++;
        if (bus.count_out !== 0 || bus.wrap_pulse !== 0 || bus.rollover_flag !== 1) begin
            n_errors++; $display("FAIL degen_up: count=%0d pulse=%b flag=%b want 0/0/1", bus.count_out, bus.wrap_pulse, bus.rollover_flag);
        end
        bus.count_dir = 0;
        step();
        n_checks++;
        if (bus.count_out !== 0 || bus.wrap_pulse !== 0 || bus.rollover_flag !== 1) begin
            n_errors++; $display("FAIL degen_down: count=%0d pulse=%b flag=%b want 0/0/1", bus.count_out, bus.wrap_pulse, bus.rollover_flag);
        end
        idle();
    endtask

    task automatic test_wrap_count();
        int ew [6] = '{1, 2, 3, 3, 3, 3};
        logic [WB-1:0] exp_w;
        do_clear();
        bus.rollover_val = 1;
        do_load(1);
        bus.count_dir = 1; bus.count_enable = 1;
        for (int i = 0; i < 6; i++) begin
            step();
`ifdef FLEX_CNT_WRAP_CNT_EN
            exp_w = WB'(ew[i]);
`else
            exp_w = '0;
`endif
            n_checks++;
            if (bus.wrap_count !== exp_w || bus.wrap_pulse !== 1 || bus.count_out !== 4'd1) begin
                n_errors++;
                $display("FAIL wrap_count[%0d]: wc=%0d pulse=%b count=%0d want %0d/1/1",
                         i, bus.wrap_count, bus.wrap_pulse, bus.count_out, exp_w);
            end
        end
        // Load must not disturb the wrap count.
        do_load(3);
        n_checks++;
        if (bus.wrap_count !== exp_w || bus.wrap_pulse !== 0) begin
            n_errors++; $display("FAIL wrap_count_load: wc=%0d pulse=%b want %0d/0", bus.wrap_count, bus.wrap_pulse, exp_w);
        end
        do_clear();
        n_checks++;
        if (bus.wrap_count !== 0 || bus.count_out !== 0) begin
            n_errors++; $display("FAIL wrap_count_clear: wc=%0d count=%0d want 0/0", bus.wrap_count, bus.count_out);
        end
    endtask

    initial begin
        idle();
        bus.load_val = 0; bus.count_dir = 1; bus.rollover_val = 0;
        n_rst = 0;
        step(); step();
        n_rst = 1;
        step();
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_priority();
        test_midrun_change();
        test_degenerate();
        test_wrap_count();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
